// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending-machine transaction sequencer:
//   - state_e      : controller state encoding (IDLE/CREDIT/CHECK/VEND/CHANGE)
//   - COIN_*       : 2-bit coin codes used on coin_code and change_code
//   - DENOM_*      : coin denominations in money units
//   - ERR_*        : err_code values
//   - coin_value() : maps a coin code to its denomination
// -----------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_CHECK  = 3'd2,
        ST_VEND   = 3'd3,
        ST_CHANGE = 3'd4
    } state_e;

    localparam logic [1:0] COIN_500  = 2'b00;
    localparam logic [1:0] COIN_1000 = 2'b01;
    localparam logic [1:0] COIN_2000 = 2'b10;
    localparam logic [1:0] COIN_5000 = 2'b11;

    localparam int unsigned DENOM_500  = 500;
    localparam int unsigned DENOM_1000 = 1000;
    localparam int unsigned DENOM_2000 = 2000;
    localparam int unsigned DENOM_5000 = 5000;

    // Product prices arrive in units of 100.
    localparam int unsigned PRICE_UNIT = 100;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_STOCK    = 2'd1;
    localparam logic [1:0] ERR_CREDIT   = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    function automatic int unsigned coin_value(input logic [1:0] code);
        int unsigned value;
        value = DENOM_500;
        case (code)
            COIN_500:  value = DENOM_500;
            COIN_1000: value = DENOM_1000;
            COIN_2000: value = DENOM_2000;
            COIN_5000: value = DENOM_5000;
            default:   value = DENOM_500;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_controller_if.sv
// -----------------------------------------------------------------------------
// vend_controller_if
// Bundles every non-clock/reset signal of the vending controller.
//   master : the controller (drives strobes, requests, change, state, credit)
//   slave  : the surrounding machine (front panel, coin counter, product
//            manager, dispenser, payout mechanism)
// Groups:
//   coin_*   : coin intake and accept/reject pulses
//   sel_*    : product selection, cancel
//   stock_*  : stock/price query handshake (req held until ack)
//   vend_*   : dispense handshake (req held until done)
//   change_* : change payout valid/ready handshake
//   state, credit, err_code : display status
// -----------------------------------------------------------------------------
interface vend_controller_if #(
    parameter int CREDIT_W = 16
);
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                coin_accept;
    logic                coin_reject;
    logic                sel_valid;
    logic [2:0]          sel_id;
    logic                cancel;
    logic                stock_req;
    logic [2:0]          stock_id;
    logic                stock_ack;
    logic                stock_avail;
    logic [7:0]          stock_price;
    logic                vend_req;
    logic [2:0]          vend_id;
    logic                vend_done;
    logic                change_valid;
    logic [1:0]          change_code;
    logic                change_ready;
    logic [2:0]          state;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          err_code;

    modport master (
        input  coin_valid, coin_code, sel_valid, sel_id, cancel,
               stock_ack, stock_avail, stock_price, vend_done, change_ready,
        output coin_accept, coin_reject, stock_req, stock_id, vend_req, vend_id,
               change_valid, change_code, state, credit, err_code
    );

    modport slave (
        output coin_valid, coin_code, sel_valid, sel_id, cancel,
               stock_ack, stock_avail, stock_price, vend_done, change_ready,
        input  coin_accept, coin_reject, stock_req, stock_id, vend_req, vend_id,
               change_valid, change_code, state, credit, err_code
    );
endinterface

// File: rtl/change_picker.sv
// -----------------------------------------------------------------------------
// change_picker
// Combinational greedy selector: returns the code of the largest coin whose
// denomination does not exceed the given credit. Below 1000 it returns the
// 500 code; the caller decides whether any change is due at all.
//   credit : remaining credit (CREDIT_W bits)
//   code   : coin code of the largest denomination <= credit
// -----------------------------------------------------------------------------
module change_picker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 16
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          code
);

    // NOTE: the output gets a default before the if-chain so every path
    // assigns it and no latch is inferred.
    always_comb begin
        code = COIN_500;
        if (credit >= CREDIT_W'(DENOM_5000)) begin
            code = COIN_5000;
        end else if (credit >= CREDIT_W'(DENOM_2000)) begin
            code = COIN_2000;
        end else if (credit >= CREDIT_W'(DENOM_1000)) begin
            code = COIN_1000;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// -----------------------------------------------------------------------------
// vend_controller
// Transaction sequencer for the vending machine: collects coins into credit,
// takes a product selection, queries stock/price, commands the dispense and
// pays back change one greedy coin at a time. All outputs are registered.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high; clears all state
//   bus   : vend_controller_if.master (coin, selection, stock, vend, change
//           handshakes plus state/credit/err_code display outputs)
// -----------------------------------------------------------------------------
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W       = 16,
    parameter int MAX_CREDIT     = 20000,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    vend_controller_if.master   bus
);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_CREDIT = 3'(ST_CREDIT);
    localparam logic [2:0] S_CHECK  = 3'(ST_CHECK);
    localparam logic [2:0] S_VEND   = 3'(ST_VEND);
    localparam logic [2:0] S_CHANGE = 3'(ST_CHANGE);

    localparam int                  TIMER_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0]  TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] MIN_CHANGE   = CREDIT_W'(DENOM_500);

    logic [2:0]          state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [1:0]          err_q;
    logic [TIMER_W-1:0]  timer_q;
    logic                coin_accept_q;
    logic                coin_reject_q;
    logic                stock_req_q;
    logic [2:0]          stock_id_q;
    logic                vend_req_q;
    logic [2:0]          vend_id_q;
    logic                change_valid_q;
    logic [1:0]          change_code_q;

    logic [CREDIT_W-1:0] coin_amt;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                coin_window;
    logic                coin_take;
    logic [CREDIT_W-1:0] price_amt;
    logic [CREDIT_W-1:0] change_amt;
    logic [CREDIT_W-1:0] credit_left;
    logic [1:0]          pick_code;

    // Coin arithmetic is one bit wider so a sum past the register width
    // still compares correctly against MAX_CREDIT.
    assign coin_amt    = CREDIT_W'(coin_value(bus.coin_code));
    assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_amt};
    assign coin_fits   = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign coin_window = (state_q == S_IDLE) || (state_q == S_CREDIT);
    // cancel and sel_valid outrank a coin presented in the same cycle.
    assign coin_take   = coin_window && bus.coin_valid && !bus.cancel
                         && !bus.sel_valid && coin_fits;

    assign price_amt   = CREDIT_W'(bus.stock_price) * CREDIT_W'(PRICE_UNIT);
    assign change_amt  = CREDIT_W'(coin_value(change_code_q));
    assign credit_left = credit_q - change_amt;

    change_picker #(.CREDIT_W(CREDIT_W)) u_change_picker (
        .credit (credit_q),
        .code   (pick_code)
    );

    // NOTE: every register here is plain state (no memory array), so all of
    // it is cleared on reset and updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            err_q          <= ERR_NONE;
            timer_q        <= '0;
            coin_accept_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            stock_req_q    <= 1'b0;
            stock_id_q     <= '0;
            vend_req_q     <= 1'b0;
            vend_id_q      <= '0;
            change_valid_q <= 1'b0;
            change_code_q  <= COIN_500;
        end else begin
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;

            if (bus.coin_valid && !coin_window) begin
                coin_reject_q <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_CREDIT: begin
                    if (bus.coin_valid) begin
                        if (coin_take) begin
                            credit_q      <= coin_sum[CREDIT_W-1:0];
                            coin_accept_q <= 1'b1;
                            err_q         <= ERR_NONE;
                            timer_q       <= '0;
                            state_q       <= S_CREDIT;
                        end else begin
                            coin_reject_q <= 1'b1;
                            if (!bus.cancel && !bus.sel_valid) begin
                                err_q <= ERR_OVERFLOW;
                            end
                        end
                    end

                    // IDLE ignores cancel and selection; only a coin moves it.
                    if (state_q == S_CREDIT) begin
                        if (bus.cancel) begin
                            state_q        <= S_CHANGE;
                            change_valid_q <= 1'b1;
                            change_code_q  <= pick_code;
                        end else if (bus.sel_valid) begin
                            state_q     <= S_CHECK;
                            stock_req_q <= 1'b1;
                            stock_id_q  <= bus.sel_id;
                            vend_id_q   <= bus.sel_id;
                        end else if (!coin_take) begin
                            if (timer_q == TIMEOUT_LAST) begin
                                state_q        <= S_CHANGE;
                                change_valid_q <= 1'b1;
                                change_code_q  <= pick_code;
                            end else begin
                                timer_q <= timer_q + TIMER_W'(1);
                            end
                        end
                    end
                end

                S_CHECK: begin
                    if (bus.stock_ack) begin
                        stock_req_q <= 1'b0;
                        if (!bus.stock_avail) begin
                            err_q   <= ERR_STOCK;
                            timer_q <= '0;
                            state_q <= S_CREDIT;
                        end else if (credit_q < price_amt) begin
                            err_q   <= ERR_CREDIT;
                            timer_q <= '0;
                            state_q <= S_CREDIT;
                        end else begin
                            credit_q   <= credit_q - price_amt;
                            vend_req_q <= 1'b1;
                            state_q    <= S_VEND;
                        end
                    end
                end

                S_VEND: begin
                    if (bus.vend_done) begin
                        vend_req_q <= 1'b0;
                        if (credit_q >= MIN_CHANGE) begin
                            state_q        <= S_CHANGE;
                            change_valid_q <= 1'b1;
                            change_code_q  <= pick_code;
                        end else begin
                            state_q  <= S_IDLE;
                            credit_q <= '0;
                        end
                    end
                end

                S_CHANGE: begin
                    // After each transfer valid drops for one cycle so the
                    // picker sees the reduced credit before the next offer.
                    if (change_valid_q && bus.change_ready) begin
                        change_valid_q <= 1'b0;
                        if (credit_left < MIN_CHANGE) begin
                            state_q  <= S_IDLE;
                            credit_q <= '0;
                        end else begin
                            credit_q <= credit_left;
                        end
                    end else if (!change_valid_q) begin
                        if (credit_q < MIN_CHANGE) begin
                            state_q  <= S_IDLE;
                            credit_q <= '0;
                        end else begin
                            change_valid_q <= 1'b1;
                            change_code_q  <= pick_code;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.credit       = credit_q;
    assign bus.err_code     = err_q;
    assign bus.coin_accept  = coin_accept_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.stock_req    = stock_req_q;
    assign bus.stock_id     = stock_id_q;
    assign bus.vend_req     = vend_req_q;
    assign bus.vend_id      = vend_id_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_code  = change_code_q;

endmodule
